// File: rtl/pipe_pkg.sv
// Shared constants for the in-order pipeline control unit: stage numbering,
// the register-file forward select value, the per-cycle control decision
// and the forward-select width helper.
package pipe_pkg;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;
    localparam int FWD_RF = 0;

    // Which priority case the pipeline is in this cycle.
    typedef enum logic [2:0] {
        CTL_RST,
        CTL_MEM,
        CTL_BR,
        CTL_LDU,
        CTL_IF,
        CTL_RUN
    } ctl_e;

    // Width of an EX operand forward select for an nstages-deep pipeline.
    function automatic int fsel_w(input int nstages);
        return $clog2(nstages - 2);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Priority match of one EX source index against the result slots.
// The lowest-numbered candidate slot whose destination matches wins;
// the caller decides which slots are eligible via cand.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int NSLOT  = 3,
    parameter int IDX_W  = 5,
    parameter int FSEL_W = 2
) (
    input  logic [IDX_W-1:0]       ex_rs,
    input  logic [NSLOT-1:0]       cand,
    input  logic [NSLOT*IDX_W-1:0] pipe_rd,
    output logic [FSEL_W-1:0]      sel
);

    // Scan from the oldest slot down so the youngest match overrides.
    always_comb begin
        sel = FSEL_W'(FWD_RF);
        for (int j = NSLOT - 1; j >= 0; j--) begin
            if (cand[j] && (pipe_rd[j*IDX_W +: IDX_W] == ex_rs)) begin
                sel = FSEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for an NSTAGES-deep in-order core: per-stage valid bits,
// pipeline-register and PC write enables, load-use interlock, taken-branch
// squash, data-cache freeze and EX operand forward selects.
// Optional macro PIPE_PERF_CNT_EN adds saturating event counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int IDX_W   = 5,
    parameter int FSEL_W  = fsel_w(NSTAGES)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            if_stall,
    input  logic                            mem_stall,
    input  logic                            br_taken,
    input  logic [IDX_W-1:0]                id_rs1,
    input  logic [IDX_W-1:0]                id_rs2,
    input  logic                            id_rs1_used,
    input  logic                            id_rs2_used,
    input  logic [IDX_W-1:0]                ex_rs1,
    input  logic [IDX_W-1:0]                ex_rs2,
    input  logic [(NSTAGES-2)*IDX_W-1:0]    pipe_rd,
    input  logic [NSTAGES-3:0]              pipe_we,
    input  logic [NSTAGES-3:0]              pipe_ld,
    output logic                            pc_we,
    output logic [NSTAGES-2:0]              stage_en,
    output logic [NSTAGES-2:0]              stage_valid,
    output logic                            flush,
    output logic [FSEL_W-1:0]               fwd_a_sel,
    output logic [FSEL_W-1:0]               fwd_b_sel
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_mem_stall,
    output logic [31:0]                     perf_ldu,
    output logic [31:0]                     perf_flush
`endif
);

    localparam int NSLOT = NSTAGES - 2;
    localparam int NV    = NSTAGES - 1;

    logic [NV-1:0]    valid_q, valid_d;
    logic [NSLOT-1:0] live, fwd_ok;
    logic             ldu;
    ctl_e             ctl;

    assign stage_valid = valid_q;

    // A slot is live when it holds a real instruction writing a nonzero register.
    always_comb begin
        live = '0;
        for (int j = 0; j < NSLOT; j++) begin
            live[j] = valid_q[j+1] & pipe_we[j] & (pipe_rd[j*IDX_W +: IDX_W] != '0);
        end
    end

    // Load-use: a load whose data will not reach WB before ID's consumer hits EX.
    always_comb begin
        ldu = 1'b0;
        for (int j = 0; j <= NSTAGES - 5; j++) begin
            if (live[j] && pipe_ld[j] &&
                ((id_rs1_used && pipe_rd[j*IDX_W +: IDX_W] == id_rs1) ||
                 (id_rs2_used && pipe_rd[j*IDX_W +: IDX_W] == id_rs2))) begin
                ldu = 1'b1;
            end
        end
        ldu = ldu & valid_q[STG_ID-1];
    end

    // Pick the priority case for this cycle.
    always_comb begin
        ctl = CTL_RUN;
        if (!reset)                             ctl = CTL_RST;
        else if (mem_stall)                     ctl = CTL_MEM;
        else if (br_taken && valid_q[STG_EX-1]) ctl = CTL_BR;
        else if (ldu)                           ctl = CTL_LDU;
        else if (if_stall)                      ctl = CTL_IF;
    end

    // Enables and next valid vector; the default is a plain shift with a new fetch.
    always_comb begin
        pc_we    = 1'b0;
        stage_en = '0;
        flush    = 1'b0;
        valid_d  = {valid_q[NV-2:0], 1'b1};
        unique case (ctl)
            CTL_RST: valid_d = '0;
            CTL_MEM: valid_d = valid_q;
            CTL_BR: begin
                pc_we        = 1'b1;
                stage_en     = '1;
                flush        = 1'b1;
                valid_d[1:0] = 2'b00;
            end
            CTL_LDU: begin
                stage_en   = {{(NV-1){1'b1}}, 1'b0};
                valid_d[1] = 1'b0;
                valid_d[0] = valid_q[0];
            end
            CTL_IF: begin
                stage_en   = '1;
                valid_d[0] = 1'b0;
            end
            default: begin
                pc_we    = 1'b1;
                stage_en = '1;
            end
        endcase
    end

    // Valid-bit register.
    always_ff @(posedge clk) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // EX itself never forwards; loads are eligible only once they reach WB.
    always_comb begin
        fwd_ok = '0;
        for (int j = 0; j < NSLOT; j++) begin
            fwd_ok[j] = live[j] & (~pipe_ld[j] | (j == NSLOT - 1));
        end
        fwd_ok[0] = 1'b0;
    end

    pipe_fwd_sel #(.NSLOT(NSLOT), .IDX_W(IDX_W), .FSEL_W(FSEL_W)) u_fwd_a (
        .ex_rs   (ex_rs1),
        .cand    (fwd_ok),
        .pipe_rd (pipe_rd),
        .sel     (fwd_a_sel)
    );

    pipe_fwd_sel #(.NSLOT(NSLOT), .IDX_W(IDX_W), .FSEL_W(FSEL_W)) u_fwd_b (
        .ex_rs   (ex_rs2),
        .cand    (fwd_ok),
        .pipe_rd (pipe_rd),
        .sel     (fwd_b_sel)
    );

`ifdef PIPE_PERF_CNT_EN
    // Saturating counters of memory-stall, load-use and flush cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_mem_stall <= '0;
            perf_ldu       <= '0;
            perf_flush     <= '0;
        end else begin
            if (ctl == CTL_MEM && perf_mem_stall != '1) perf_mem_stall <= perf_mem_stall + 32'd1;
            if (ctl == CTL_LDU && perf_ldu != '1)       perf_ldu       <= perf_ldu + 32'd1;
            if (ctl == CTL_BR && perf_flush != '1)      perf_flush     <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 5-stage and a 6-stage instance
// driven through reset fill, load-use, forwarding, branch, stall cases.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       if_stall, mem_stall, br_taken;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2;
    logic       id_rs1_used, id_rs2_used;

    logic [14:0] p5_rd;
    logic [2:0]  p5_we, p5_ld;
    logic        d5_pc_we, d5_flush;
    logic [3:0]  d5_en, d5_sv;
    logic [1:0]  d5_fa, d5_fb;

    logic [19:0] p6_rd;
    logic [3:0]  p6_we, p6_ld;
    logic        d6_pc_we, d6_flush;
    logic [4:0]  d6_en, d6_sv;
    logic [1:0]  d6_fa, d6_fb;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] d5_pm, d5_pl, d5_pf, d6_pm, d6_pl, d6_pf;
`endif

    int nvec = 0;
    int nerr = 0;

    pipe_hazard_ctrl #(.NSTAGES(5), .IDX_W(5)) d5 (
        .clk(clk), .reset(reset), .if_stall(if_stall), .mem_stall(mem_stall),
        .br_taken(br_taken), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .pipe_rd(p5_rd), .pipe_we(p5_we),
        .pipe_ld(p5_ld), .pc_we(d5_pc_we), .stage_en(d5_en), .stage_valid(d5_sv),
        .flush(d5_flush), .fwd_a_sel(d5_fa), .fwd_b_sel(d5_fb)
`ifdef PIPE_PERF_CNT_EN
        , .perf_mem_stall(d5_pm), .perf_ldu(d5_pl), .perf_flush(d5_pf)
`endif
    );

    pipe_hazard_ctrl #(.NSTAGES(6), .IDX_W(5)) d6 (
        .clk(clk), .reset(reset), .if_stall(if_stall), .mem_stall(mem_stall),
        .br_taken(br_taken), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .pipe_rd(p6_rd), .pipe_we(p6_we),
        .pipe_ld(p6_ld), .pc_we(d6_pc_we), .stage_en(d6_en), .stage_valid(d6_sv),
        .flush(d6_flush), .fwd_a_sel(d6_fa), .fwd_b_sel(d6_fb)
`ifdef PIPE_PERF_CNT_EN
        , .perf_mem_stall(d6_pm), .perf_ldu(d6_pl), .perf_flush(d6_pf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; if_stall = 1'b0; mem_stall = 1'b0; br_taken = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        p5_rd = '0; p5_we = '0; p5_ld = '0;
        p6_rd = '0; p6_we = '0; p6_ld = '0;
        #1;
        // outputs forced quiet while reset is low, even with a branch asserted
        chk("rst_pc_we", d5_pc_we, 1'b0);
        chk("rst_stage_en", d5_en, 4'b0000);
        chk("rst_flush", d5_flush, 1'b0);

        tick(); reset = 1'b1; br_taken = 1'b0; #1;
        chk("fill0_sv", d5_sv, 4'b0000);
        chk("fill0_pc_we", d5_pc_we, 1'b1);
        tick(); chk("fill1_sv", d5_sv, 4'b0001); chk("fill1_pc_we", d5_pc_we, 1'b1);
        tick(); chk("fill2_sv", d5_sv, 4'b0011); chk("fill2_pc_we", d5_pc_we, 1'b1);
        tick(); chk("fill3_sv", d5_sv, 4'b0111); chk("fill3_pc_we", d5_pc_we, 1'b1);
        tick(); chk("fill4_sv", d5_sv, 4'b1111); chk("fill4_en", d5_en, 4'b1111);

        // load to x5 in EX, ID reads x5 -> interlock
        p5_we = 3'b001; p5_ld = 3'b001; p5_rd = {10'd0, 5'd5};
        id_rs1 = 5'd5; id_rs1_used = 1'b1; #1;
        chk("ldu_pc_we", d5_pc_we, 1'b0);
        chk("ldu_en", d5_en, 4'b1110);
        chk("ldu_flush", d5_flush, 1'b0);
        tick(); chk("ldu_bubble_sv", d5_sv, 4'b1101);
        // load now in M: no interlock, and not yet forwardable
        p5_we = 3'b010; p5_ld = 3'b010; p5_rd = {5'd0, 5'd5, 5'd0}; ex_rs1 = 5'd5; #1;
        chk("ldu_m_pc_we", d5_pc_we, 1'b1);
        chk("ldu_m_fwd_a", d5_fa, 2'd0);
        tick(); chk("ldu_wb_sv", d5_sv, 4'b1011);
        p5_we = 3'b100; p5_ld = 3'b100; p5_rd = {5'd5, 10'd0}; id_rs1_used = 1'b0; #1;
        chk("ldu_wb_fwd_a", d5_fa, 2'd2);
        tick(); p5_we = '0; p5_ld = '0; p5_rd = '0; ex_rs1 = '0;
        tick(); chk("refill_sv", d5_sv, 4'b1111);

        // ALU forwarding priority
        p5_we = 3'b110; p5_ld = 3'b000; p5_rd = {5'd7, 5'd7, 5'd0}; ex_rs2 = 5'd7; #1;
        chk("fwd_m_wins", d5_fb, 2'd1);
        p5_rd = {5'd7, 5'd0, 5'd0}; #1;
        chk("fwd_wb_only", d5_fb, 2'd2);
        p5_rd = '0; #1;
        chk("fwd_rd0", d5_fb, 2'd0);
        p5_rd = {5'd7, 5'd7, 5'd0}; p5_ld = 3'b010; #1;
        chk("fwd_skip_m_load", d5_fb, 2'd2);
        p5_ld = 3'b100; #1;
        chk("fwd_wb_load_m_alu", d5_fb, 2'd1);
        p5_we = '0; p5_ld = '0; p5_rd = '0; ex_rs2 = '0;

        // taken branch with valid EX
        br_taken = 1'b1; #1;
        chk("br_flush", d5_flush, 1'b1);
        chk("br_pc_we", d5_pc_we, 1'b1);
        chk("br_en", d5_en, 4'b1111);
        tick();
        chk("br_sv", d5_sv, 4'b1100);
        chk("br_invalid_ex_flush", d5_flush, 1'b0);
        chk("br_invalid_ex_pc_we", d5_pc_we, 1'b1);
        br_taken = 1'b0;
        tick(); tick(); chk("post_br_sv", d5_sv, 4'b0011);

        // mem_stall for three cycles with a taken branch waiting in EX
        mem_stall = 1'b1; br_taken = 1'b1; #1;
        chk("ms_en", d5_en, 4'b0000);
        chk("ms_flush", d5_flush, 1'b0);
        chk("ms_pc_we", d5_pc_we, 1'b0);
        tick(); chk("ms1_sv", d5_sv, 4'b0011); chk("ms1_flush", d5_flush, 1'b0);
        tick(); chk("ms2_sv", d5_sv, 4'b0011); chk("ms2_en", d5_en, 4'b0000);
        tick(); mem_stall = 1'b0; #1;
        chk("ms_rel_flush", d5_flush, 1'b1);
        chk("ms_rel_pc_we", d5_pc_we, 1'b1);
        tick(); br_taken = 1'b0;
        chk("ms_rel_sv", d5_sv, 4'b0100);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_mem_stall", d5_pm, 32'd3);
        chk("perf_ldu", d5_pl, 32'd1);
        chk("perf_flush", d5_pf, 32'd2);
`endif

        // fetch stall injects an empty ID
        if_stall = 1'b1; #1;
        chk("ifs_pc_we", d5_pc_we, 1'b0);
        chk("ifs_en", d5_en, 4'b1111);
        tick(); if_stall = 1'b0;
        chk("ifs_sv", d5_sv, 4'b1000);
        tick(); tick(); chk("ifs_refill_sv", d5_sv, 4'b0011);

        // load-use only counts used sources and nonzero rd
        p5_we = 3'b001; p5_ld = 3'b001; p5_rd = {10'd0, 5'd3};
        id_rs2 = 5'd3; id_rs2_used = 1'b0; #1;
        chk("ldu_unused_pc_we", d5_pc_we, 1'b1);
        id_rs2_used = 1'b1; #1;
        chk("ldu_rs2_pc_we", d5_pc_we, 1'b0);
        chk("ldu_rs2_en", d5_en, 4'b1110);
        p5_rd = '0; id_rs2 = '0; #1;
        chk("ldu_rd0_pc_we", d5_pc_we, 1'b1);
        p5_we = '0; p5_ld = '0; id_rs2_used = 1'b0;

        // 6-stage instance: fresh reset and fill
        reset = 1'b0;
        tick(); reset = 1'b1;
        repeat (5) tick();
        chk("d6_fill_sv", d6_sv, 5'b11111);
        // load in stage 3 (slot 1), ID uses x9 -> one bubble
        p6_we = 4'b0010; p6_ld = 4'b0010; p6_rd = {10'd0, 5'd9, 5'd0};
        id_rs1 = 5'd9; id_rs1_used = 1'b1; #1;
        chk("d6_ldu_pc_we", d6_pc_we, 1'b0);
        chk("d6_ldu_en", d6_en, 5'b11110);
        tick(); chk("d6_bubble_sv", d6_sv, 5'b11101);
        // load in stage 4 (slot 2): no interlock
        p6_we = 4'b0100; p6_ld = 4'b0100; p6_rd = {5'd0, 5'd9, 10'd0}; #1;
        chk("d6_m2_pc_we", d6_pc_we, 1'b1);
        chk("d6_m2_en", d6_en, 5'b11111);
        tick(); chk("d6_wb_sv", d6_sv, 5'b11011);
        // consumer in EX, load in WB; a younger load in stage 4 is not eligible
        p6_we = 4'b1100; p6_ld = 4'b1100; p6_rd = {5'd9, 5'd9, 10'd0};
        ex_rs1 = 5'd9; ex_rs2 = 5'd9; id_rs1_used = 1'b0; #1;
        chk("d6_fwd_a_wb", d6_fa, 2'd3);
        chk("d6_fwd_b_wb", d6_fb, 2'd3);
        p6_ld = 4'b1000; #1;
        chk("d6_fwd_a_alu_m2", d6_fa, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
